regfile_multiport: RTL and testbench

Parametrised general-purpose register file for the RISC-V core: NUM_REGS × DATA_WIDTH storage, two combinational read ports, one synchronous write port, with x0 hard-wired to zero. Adds a synchronous clear sweep (after reset or on request) and a per-register pending-write scoreboard for hazard detection in the decode stage. Sits between decode (rs1/rs2/reservation) and writeback (rd/wd/wr).

---
 rtl/regfile_multiport_if.sv | 45 ++++
 rtl/regfile_multiport.sv | 176 +++++++++++++++++
 tb/tb_regfile_multiport.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_if.sv
// ---------------------------------------------------------------------------
// regfile_multiport_if
//   Bundles the decode-side (read/reserve) and writeback-side (write) signals
//   of the multiport register file, plus its clear request and busy status.
//
//   master modport : used by the pipeline (drives indices/data, sees reads)
//   slave modport  : used by regfile_multiport
//
//   Signals:
//     clr            start a clear sweep
//     rs1, rs2       read indices
//     rd, wr, wd     write index / enable / data
//     rsv_en, rsv_rd reserve a destination as pending
//     rd1, rd2       read data
//     pend1, pend2   pending-write flags for rs1 / rs2
//     busy           clear sweep in progress
// ---------------------------------------------------------------------------
interface regfile_multiport_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  clr;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] rd;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic                  rsv_en;
  logic [ADDR_WIDTH-1:0] rsv_rd;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic                  pend1;
  logic                  pend2;
  logic                  busy;

  modport master (
    output clr, rs1, rs2, rd, wr, wd, rsv_en, rsv_rd,
    input  rd1, rd2, pend1, pend2, busy
  );

  modport slave (
    input  clr, rs1, rs2, rd, wr, wd, rsv_en, rsv_rd,
    output rd1, rd2, pend1, pend2, busy
  );
endinterface

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
//   NUM_REGS x DATA_WIDTH general-purpose register file with x0 hard-wired to
//   zero, two combinational read ports and one synchronous write port.
//   A clear sweep (after reset or on clr) zeroes x1..x(NUM_REGS-1), one
//   register per cycle, while busy is high. A per-register pending-write
//   scoreboard lets decode detect RAW hazards on rs1/rs2.
//
//   Ports:
//     clk  clock, all state updates on the rising edge
//     rst  synchronous active-high reset (starts a clear sweep)
//     bus  regfile_multiport_if.slave (clr, rs1/rs2, rd/wr/wd, rsv_en/rsv_rd,
//          rd1/rd2, pend1/pend2, busy)
//
//   Optional feature: define REGFILE_BYPASS_EN to forward the write data of
//   the current cycle to a read port addressing the same register (and mask
//   its pending flag). Without it, writes become visible one cycle later.
// ---------------------------------------------------------------------------
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_multiport_if.slave    bus
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] counter_reg, counter_next;

  // Storage: x0 slot exists but is never written and never read out.
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  pend_reg [NUM_REGS];

  logic                  busy;
  logic                  wr_ok;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic                  pend1, pend2;

  assign busy  = (state_reg == CLEAR);
  assign wr_ok = bus.wr && (bus.rd != '0);

  // -------------------------------------------------------------------------
  // Sweep FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      counter_reg <= FIRST_IDX;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

  // The sweep and the writeback share the single RAM write port: during
  // CLEAR the port is owned by the sweep, which is why writes are dropped.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    mem_we       = 1'b0;
    mem_waddr    = bus.rd;
    mem_wdata    = bus.wd;
    case (state_reg)
      IDLE: begin
        mem_we = wr_ok;
        if (bus.clr) begin
          state_next   = CLEAR;
          counter_next = FIRST_IDX;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = counter_reg;
        mem_wdata = '0;
        // Counter stops at the last index; it never wraps.
        if (counter_reg == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          counter_next = counter_reg + 1'b1;
        end
      end
      default: begin
        state_next   = CLEAR;
        counter_next = FIRST_IDX;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Register storage (single write port, no reset: the sweep clears it)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Pending-write scoreboard, one flag per register.
  // A reservation beats a completing write to the same index: the newly
  // issued producer supersedes the one now writing back.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      if (gi == 0) begin : g_x0
        always_ff @(posedge clk) begin
          pend_reg[gi] <= 1'b0;
        end
      end else begin : g_xn
        always_ff @(posedge clk) begin
          if (rst || busy) begin
            pend_reg[gi] <= 1'b0;
          end else if (bus.rsv_en && (bus.rsv_rd == ADDR_WIDTH'(gi))) begin
            pend_reg[gi] <= 1'b1;
          end else if (bus.wr && (bus.rd == ADDR_WIDTH'(gi))) begin
            pend_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Read ports: x0 and the whole sweep read as zero / not pending.
  // -------------------------------------------------------------------------
  always_comb begin
    rd1   = '0;
    pend1 = 1'b0;
    if (!busy && (bus.rs1 != '0)) begin
      rd1   = mem[bus.rs1];
      pend1 = pend_reg[bus.rs1];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.rd == bus.rs1)) begin
        rd1   = bus.wd;
        pend1 = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rd2   = '0;
    pend2 = 1'b0;
    if (!busy && (bus.rs2 != '0)) begin
      rd2   = mem[bus.rs2];
      pend2 = pend_reg[bus.rs2];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.rd == bus.rs2)) begin
        rd2   = bus.wd;
        pend2 = 1'b0;
      end
`endif
    end
  end

  assign bus.rd1   = rd1;
  assign bus.rd2   = rd2;
  assign bus.pend1 = pend1;
  assign bus.pend2 = pend2;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport
//   Scoreboard bench: each stimulus cycle pushes the expected outputs computed
//   by a behavioural model; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_multiport #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          pend1;
    logic          pend2;
    logic          busy;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle_no     = 0;

  // Behavioural model: architectural register contents, reservation flags,
  // and how many sweep cycles remain.
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];
  int            m_sweep_left = 0;
  bit            m_valid      = 1'b0;

  function automatic void m_wipe();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic void m_read(input logic [AW-1:0] rs,
                                 output logic [DW-1:0] data,
                                 output logic pend);
    data = '0;
    pend = 1'b0;
    if (m_sweep_left == 0 && rs != 0) begin
      data = m_regs[rs];
      pend = m_pend[rs];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr && bus.rd == rs) begin
        data = bus.wd;
        pend = 1'b0;
      end
`endif
    end
  endfunction

  // Apply one cycle of inputs, push expectations, advance the model.
  task automatic cyc(input bit r, input bit c,
                     input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input logic [AW-1:0] wrd, input bit w, input logic [DW-1:0] d,
                     input bit re, input logic [AW-1:0] rr);
    exp_t e;
    rst        = r;
    bus.clr    = c;
    bus.rs1    = a1;
    bus.rs2    = a2;
    bus.rd     = wrd;
    bus.wr     = w;
    bus.wd     = d;
    bus.rsv_en = re;
    bus.rsv_rd = rr;
    if (m_valid) begin
      m_read(a1, e.rd1, e.pend1);
      m_read(a2, e.rd2, e.pend2);
      e.busy = (m_sweep_left > 0);
      e.cyc  = cycle_no;
      exp_q.push_back(e);
    end
    if (r) begin
      m_wipe();
      m_sweep_left = NR - 1;
      m_valid      = 1'b1;
    end else if (m_sweep_left > 0) begin
      m_sweep_left--;
    end else begin
      if (w && wrd != 0) begin
        m_regs[wrd] = d;
        m_pend[wrd] = 1'b0;
      end
      if (re && rr != 0) m_pend[rr] = 1'b1;
      if (c) begin
        // Sweep ends with everything zero and nothing pending.
        m_wipe();
        m_sweep_left = NR - 1;
      end
    end
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  task automatic idle_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cyc(0, 0, a1, a2, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_rd(input logic [AW-1:0] wrd, input logic [DW-1:0] d,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cyc(0, 0, a1, a2, wrd, 1, d, 0, 0);
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_compared++;
      if (bus.rd1 !== e.rd1) begin
        n_mismatched++;
        $display("FAIL rd1 cyc=%0d rs1=%0d got=%h exp=%h", e.cyc, bus.rs1, bus.rd1, e.rd1);
      end
      n_compared++;
      if (bus.rd2 !== e.rd2) begin
        n_mismatched++;
        $display("FAIL rd2 cyc=%0d rs2=%0d got=%h exp=%h", e.cyc, bus.rs2, bus.rd2, e.rd2);
      end
      n_compared++;
      if (bus.pend1 !== e.pend1) begin
        n_mismatched++;
        $display("FAIL pend1 cyc=%0d rs1=%0d got=%b exp=%b", e.cyc, bus.rs1, bus.pend1, e.pend1);
      end
      n_compared++;
      if (bus.pend2 !== e.pend2) begin
        n_mismatched++;
        $display("FAIL pend2 cyc=%0d rs2=%0d got=%b exp=%b", e.cyc, bus.rs2, bus.pend2, e.pend2);
      end
      n_compared++;
      if (bus.busy !== e.busy) begin
        n_mismatched++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, bus.busy, e.busy);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.clr = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0; bus.wr = 0;
    bus.wd = 0; bus.rsv_en = 0; bus.rsv_rd = 0;

    // Reset, then the full sweep with reads across x1..x31; writes dropped.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < NR; i++) begin
      cyc(0, 0, AW'(i), AW'(NR - i), AW'(i), 1, 32'hDEAD_0000 + i, 1, AW'(i));
    end
    for (int i = 0; i < NR; i += 2) idle_rd(AW'(i), AW'(i + 1));

    // Write/read and x0 handling.
    wr_rd(2, 32'd5, 0, 0);
    wr_rd(3, 32'd10, 2, 3);
    idle_rd(2, 3);
    wr_rd(0, 32'hFFFF_FFFF, 0, 0);
    idle_rd(0, 0);

    // Forwarding / latency on x7.
    wr_rd(7, 32'h1111_1111, 0, 0);
    wr_rd(7, 32'hA5A5_A5A5, 7, 7);
    idle_rd(7, 7);

    // Scoreboard: reserve, complete, same-cycle reserve+write.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5);
    idle_rd(5, 5);
    wr_rd(5, 32'h55, 5, 5);
    idle_rd(5, 5);
    cyc(0, 0, 5, 5, 5, 1, 32'h66, 1, 5);
    idle_rd(5, 5);
    cyc(0, 0, 5, 6, 5, 1, 32'h77, 1, 6);
    idle_rd(5, 6);

    // clr mid-run with live data and reservations.
    wr_rd(1, 32'd1, 0, 0);
    wr_rd(4, 32'd10, 1, 4);
    cyc(0, 0, 4, 5, 0, 0, 0, 1, 5);
    cyc(0, 1, 4, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR + 2; i++) begin
      cyc(0, 1, AW'(i % NR), 5, AW'(i % NR), 1, 32'hBAD0_0000 + i, 1, AW'(i % NR));
    end
    for (int i = 0; i < NR; i += 2) idle_rd(AW'(i), AW'(i + 1));

    // rst in the middle of a sweep (counter at 12).
    wr_rd(9, 32'h99, 9, 0);
    cyc(1, 0, 9, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) idle_rd(9, 9);
    cyc(1, 0, 9, 9, 9, 1, 32'h1, 0, 0);
    for (int i = 0; i < NR + 1; i++) idle_rd(9, 1);

    // Randomized traffic; small index range half the time to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] a1, a2, wrd, rr;
      bit r, c, w, re;
      bit narrow;
      narrow = $urandom_range(0, 1) == 1;
      a1  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      a2  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wrd = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      rr  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      w   = $urandom_range(0, 2) != 0;
      re  = $urandom_range(0, 2) == 0;
      c   = $urandom_range(0, 199) == 0;
      r   = $urandom_range(0, 599) == 0;
      cyc(r, c, a1, a2, wrd, w, $urandom, re, rr);
    end
    idle_rd(0, 0);

    // Every pushed expectation must have been consumed by the monitor.
    @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
